// File: rtl/uart_tx_engine.sv
// uart_tx_engine: serialises one byte into an 11-bit UART frame (start, 7/8 data, optional parity, stop padding)
module uart_tx_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [7:0]  DATA,
    input  logic [18:0] max,
    input  logic        EIGHT,
    input  logic        PEN,
    input  logic        OHEL,
    output logic        TXRDY,
    output logic        TX
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
    logic [0:0]  state;
    logic [18:0] bit_cnt;
    logic [3:0]  btu_cnt;
    logic [10:0] shreg;
    logic [10:0] frame;
    logic        par;
    logic        b8;
    logic        b9;
    logic        start;
    logic        btu;
    logic        done;
    // frame assembly from live inputs (captured only on an accepted load) and bit-time strobes
    always_comb begin
        par   = ^(DATA & {EIGHT, 7'h7f}) ^ OHEL;
        b8    = EIGHT ? DATA[7] : (PEN ? par : 1'b1);
        b9    = (EIGHT & PEN) ? par : 1'b1;
        frame = {1'b1, b9, b8, DATA[6:0], 1'b0};
        start = (state == IDLE) & load;
        btu   = (state == SHIFT) & (bit_cnt == max);
        done  = btu & (btu_cnt == 4'd10);
    end
    // state, bit-time counter, BTU counter and frame shift register; TX is the register LSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            btu_cnt <= '0;
            shreg   <= '1;
        end else if (start) begin
            state <= SHIFT;
            shreg <= frame;
        end else if (state == SHIFT) begin
            bit_cnt <= btu ? '0 : bit_cnt + 19'd1;
            if (btu) begin
                shreg   <= {1'b1, shreg[10:1]};
                btu_cnt <= done ? '0 : btu_cnt + 4'd1;
            end
            if (done)
                state <= IDLE;
        end
    end
    assign TXRDY = (state == IDLE);
    assign TX    = shreg[0];
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: random and directed stimulus checked every cycle against a frame-level model
module tb_uart_tx_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        EIGHT = 1'b0;
    logic        PEN = 1'b0;
    logic        OHEL = 1'b0;
    logic [7:0]  DATA = 8'h00;
    logic [18:0] max = 19'd0;
    logic        TXRDY;
    logic        TX;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        m_busy = 1'b0;
    int          m_t = 0;
    logic [10:0] m_fr = '1;

    uart_tx_engine dut (.clk(clk), .rst(rst), .load(load), .DATA(DATA), .max(max), .EIGHT(EIGHT),
                        .PEN(PEN), .OHEL(OHEL), .TXRDY(TXRDY), .TX(TX));

    always #5 clk = ~clk;

    function automatic logic [10:0] build(input logic [7:0] d, input logic e, input logic p, input logic o);
        logic [10:0] f;
        int k;
        int ones;
        f = '1;
        f[0] = 1'b0;
        k = 1;
        ones = 0;
        for (int i = 0; i < (e ? 8 : 7); i++) begin
            f[k] = d[i];
            ones += int'(d[i]);
            k++;
        end
        if (p)
            f[k] = (ones % 2 == 1) ^ o;
        return f;
    endfunction

    task automatic check(input string nm, input logic a, input logic e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s at %0t: got %b want %b", nm, $time, a, e);
        end
    endtask

    // model: a frame is busy for 11*(max+1) cycles after an accepted load; loads while busy vanish
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_t <= 0;
        end else if (m_busy) begin
            m_t <= m_t + 1;
            if (m_t + 1 == 11 * (int'(max) + 1))
                m_busy <= 1'b0;
        end else if (load) begin
            m_busy <= 1'b1;
            m_t <= 0;
            m_fr <= build(DATA, EIGHT, PEN, OHEL);
        end
    end

    // per-cycle compare of TX and TXRDY against the model, away from the active edge
    always @(negedge clk) begin
        logic etx;
        etx = (rst || !m_busy) ? 1'b1 : m_fr[m_t / (int'(max) + 1)];
        check("tx_model", TX, etx);
        check("txrdy_model", TXRDY, rst || !m_busy);
    end

    task automatic send(input logic [7:0] d, input logic e, input logic p, input logic o, input int m);
        @(posedge clk);
        #1;
        DATA = d; EIGHT = e; PEN = p; OHEL = o; max = 19'(m); load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0; DATA = ~d; EIGHT = ~e; PEN = ~p; OHEL = ~o;
    endtask

    task automatic check_frame(input logic [10:0] ex, input int m);
        for (int i = 0; i < 11 * (m + 1); i++) begin
            @(negedge clk);
            check("lit_tx", TX, ex[i / (m + 1)]);
            check("lit_busy", TXRDY, 1'b0);
        end
        @(negedge clk);
        check("lit_done", TXRDY, 1'b1);
    endtask

    task automatic wait_idle();
        load = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (TXRDY)
                return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL idle_timeout at %0t: TXRDY still %b after 400 cycles", $time, TXRDY);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", TX, 1'b1);
        check("rst_rdy", TXRDY, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        send(8'hA5, 1'b1, 1'b1, 1'b0, 3);
        check_frame(11'b10101001010, 3);
        send(8'h81, 1'b0, 1'b1, 1'b1, 1);
        check_frame(11'b11000000010, 1);
        send(8'h00, 1'b0, 1'b0, 1'b0, 0);
        check_frame(11'b11100000000, 0);
        send(8'h5A, 1'b1, 1'b0, 1'b0, 2);
        repeat (10) @(posedge clk);
        #1 DATA = 8'hFF; load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        repeat (21) @(posedge clk);
        #1 load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("ignored_load_rdy", TXRDY, 1'b1);
        end
        send(8'hC3, 1'b1, 1'b1, 1'b1, 2);
        repeat (33) @(posedge clk);
        #1 load = 1'b1; DATA = 8'h3C;
        @(posedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        check("b2b_tx", TX, 1'b0);
        check("b2b_rdy", TXRDY, 1'b0);
        wait_idle();
        send(8'h00, 1'b1, 1'b1, 1'b0, 9);
        repeat (53) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_tx", TX, 1'b1);
        check("arst_rdy", TXRDY, 1'b1);
        @(posedge clk);
        #1;
        DATA = 8'h3C; EIGHT = 1'b1; PEN = 1'b1; OHEL = 1'b0; load = 1'b1; rst = 1'b0;
        @(posedge clk);
        #1 load = 1'b0;
        check_frame(11'b10001111000, 9);
        for (int b = 0; b < 8; b++) begin
            wait_idle();
            max = 19'($urandom_range(0, 4));
            for (int c = 0; c < 500; c++) begin
                @(posedge clk);
                #1;
                load = ($urandom_range(0, 3) == 0);
                DATA = 8'($urandom);
                {EIGHT, PEN, OHEL} = ($urandom_range(0, 1) == 1) ? 3'(b) : 3'($urandom);
            end
        end
        wait_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog at %0t: bench did not finish", $time);
        $fatal(1, "watchdog");
    end
endmodule
